// File: rtl/fwd_hazard_ctrl_if.sv
// Pipeline <-> forwarding/hazard controller bundle: ID-stage tags in, mux selectors and stall controls out.
interface fwd_hazard_ctrl_if #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 32
);
  logic [REG_BITS-1:0] id_rs;
  logic [REG_BITS-1:0] id_rt;
  logic [REG_BITS-1:0] id_dest;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                flush;
  logic [1:0]          fwd_a_sel;
  logic [1:0]          fwd_b_sel;
  logic                stall;
  logic                idex_bubble;
  logic                stats_clr;
  logic [CNT_BITS-1:0] stall_count;
  logic [CNT_BITS-1:0] fwd_count;

  modport master (
    output id_rs, id_rt, id_dest, id_reg_write, id_mem_read, flush, stats_clr,
    input  fwd_a_sel, fwd_b_sel, stall, idex_bubble, stall_count, fwd_count
  );

  modport slave (
    input  id_rs, id_rt, id_dest, id_reg_write, id_mem_read, flush, stats_clr,
    output fwd_a_sel, fwd_b_sel, stall, idex_bubble, stall_count, fwd_count
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for a 5-stage MIPS pipeline (shadow tag pipeline).
// Optional statistics counters are built when FWD_STATS_EN is defined.
module fwd_hazard_ctrl #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  fwd_hazard_ctrl_if.slave bus
);

  logic [REG_BITS-1:0] ex_rs_p0, ex_rt_p0, ex_dest_p0;
  logic                ex_rw_p0, ex_mr_p0;
  logic [REG_BITS-1:0] mem_dest_p1;
  logic                mem_rw_p1;
  logic [REG_BITS-1:0] wb_dest_p2;
  logic                wb_rw_p2;
  logic                hz;
  logic [1:0]          sel_a, sel_b;

  // EX/MEM result is newer than MEM/WB, so it is tested first; $0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_BITS-1:0] op,
    input logic [REG_BITS-1:0] mem_dest, input logic mem_rw,
    input logic [REG_BITS-1:0] wb_dest,  input logic wb_rw
  );
    if (mem_rw && (mem_dest != '0) && (mem_dest == op))
      return 2'd2;
    else if (wb_rw && (wb_dest != '0) && (wb_dest == op))
      return 2'd1;
    else
      return 2'd0;
  endfunction

  // ID -> EX shadow stage
  always_ff @(posedge clk) begin
    if (reset || bus.idex_bubble) begin
      ex_rs_p0   <= '0;
      ex_rt_p0   <= '0;
      ex_dest_p0 <= '0;
      ex_rw_p0   <= 1'b0;
      ex_mr_p0   <= 1'b0;
    end else begin
      ex_rs_p0   <= bus.id_rs;
      ex_rt_p0   <= bus.id_rt;
      ex_dest_p0 <= bus.id_dest;
      ex_rw_p0   <= bus.id_reg_write;
      ex_mr_p0   <= bus.id_mem_read;
    end
  end

  // EX -> MEM -> WB shadow stages
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_dest_p1 <= '0;
      mem_rw_p1   <= 1'b0;
      wb_dest_p2  <= '0;
      wb_rw_p2    <= 1'b0;
    end else begin
      mem_dest_p1 <= ex_dest_p0;
      mem_rw_p1   <= ex_rw_p0;
      wb_dest_p2  <= mem_dest_p1;
      wb_rw_p2    <= mem_rw_p1;
    end
  end

  always_comb begin
    sel_a = fwd_sel(ex_rs_p0, mem_dest_p1, mem_rw_p1, wb_dest_p2, wb_rw_p2);
    sel_b = fwd_sel(ex_rt_p0, mem_dest_p1, mem_rw_p1, wb_dest_p2, wb_rw_p2);
    hz    = ex_mr_p0 && (ex_dest_p0 != '0) &&
            ((ex_dest_p0 == bus.id_rs) || (ex_dest_p0 == bus.id_rt));
  end

  // A flushed ID instruction is dead, so it is bubbled but never held.
  assign bus.fwd_a_sel   = sel_a;
  assign bus.fwd_b_sel   = sel_b;
  assign bus.stall       = hz && !bus.flush;
  assign bus.idex_bubble = hz || bus.flush;

`ifdef FWD_STATS_EN
  logic [CNT_BITS-1:0] stall_cnt, fwd_cnt;
  logic [1:0]          fwd_inc;

  function automatic logic [CNT_BITS-1:0] sat_add(
    input logic [CNT_BITS-1:0] cnt, input logic [1:0] inc
  );
    logic [CNT_BITS:0] sum;
    sum = {1'b0, cnt} + {{(CNT_BITS-1){1'b0}}, inc};
    return sum[CNT_BITS] ? {CNT_BITS{1'b1}} : sum[CNT_BITS-1:0];
  endfunction

  assign fwd_inc = {1'b0, (sel_a != 2'd0)} + {1'b0, (sel_b != 2'd0)};

  always_ff @(posedge clk) begin
    if (reset || bus.stats_clr) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      stall_cnt <= sat_add(stall_cnt, {1'b0, bus.stall});
      fwd_cnt   <= sat_add(fwd_cnt, fwd_inc);
    end
  end

  assign bus.stall_count = stall_cnt;
  assign bus.fwd_count   = fwd_cnt;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = bus.stats_clr;
  assign bus.stall_count  = '0;
  assign bus.fwd_count    = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl: forwarding priority, load-use stall, flush, $0 and reset cases.
module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fwd_hazard_ctrl_if #(.REG_BITS(5), .CNT_BITS(32)) bus ();

  fwd_hazard_ctrl #(.REG_BITS(5), .CNT_BITS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                       input logic rw, input logic mr, input logic fl);
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_dest      = dest;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.flush        = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    issue(0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic load_use();
    issue(9, 8, 8, 1, 1, 0);
    tick();
    issue(8, 8, 10, 1, 0, 0);
    tick();
    tick();
    issue(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    reset         = 1'b1;
    bus.stats_clr = 1'b0;
    issue(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    reset = 1'b0;

    @(negedge clk);
    check("rst_sel_a", 32'(bus.fwd_a_sel), 0);
    check("rst_sel_b", 32'(bus.fwd_b_sel), 0);
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_bubble", 32'(bus.idex_bubble), 0);
    check("rst_stall_cnt", bus.stall_count, 0);
    check("rst_fwd_cnt", bus.fwd_count, 0);
    tick();

    // add $3,$1,$2 ; sub $4,$3,$5
    issue(1, 2, 3, 1, 0, 0); tick();
    issue(3, 5, 4, 1, 0, 0); tick();
    issue(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("exmem_sel_a", 32'(bus.fwd_a_sel), 2);
    check("exmem_sel_b", 32'(bus.fwd_b_sel), 0);
    tick();
    nops(3);

    // add $3 ; nop ; or $6,$7,$3
    issue(1, 2, 3, 1, 0, 0); tick();
    issue(0, 0, 0, 0, 0, 0); tick();
    issue(7, 3, 6, 1, 0, 0); tick();
    issue(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("memwb_sel_a", 32'(bus.fwd_a_sel), 0);
    check("memwb_sel_b", 32'(bus.fwd_b_sel), 1);
    tick();
    nops(3);

    // add $3 ; add $3 ; or $6,$7,$3 -> newest (EX/MEM) wins
    issue(1, 2, 3, 1, 0, 0); tick();
    issue(1, 2, 3, 1, 0, 0); tick();
    issue(7, 3, 6, 1, 0, 0); tick();
    issue(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("prio_sel_b", 32'(bus.fwd_b_sel), 2);
    tick();
    nops(3);

    // lw $8,0($9) ; add $10,$8,$8
    issue(9, 8, 8, 1, 1, 0);
    @(negedge clk);
    check("lw_nostall", 32'(bus.stall), 0);
    tick();
    issue(8, 8, 10, 1, 0, 0);
    @(negedge clk);
    check("lu_stall", 32'(bus.stall), 1);
    check("lu_bubble", 32'(bus.idex_bubble), 1);
    tick();
    @(negedge clk);
    check("lu_stall_clr", 32'(bus.stall), 0);
    check("lu_bubble_clr", 32'(bus.idex_bubble), 0);
    tick();
    issue(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("lu_sel_a", 32'(bus.fwd_a_sel), 1);
    check("lu_sel_b", 32'(bus.fwd_b_sel), 1);
    tick();
    nops(3);

    // lw $8 ; dependent add flushed in the same cycle
    issue(9, 8, 8, 1, 1, 0); tick();
    issue(8, 8, 10, 1, 0, 1);
    @(negedge clk);
    check("fl_stall", 32'(bus.stall), 0);
    check("fl_bubble", 32'(bus.idex_bubble), 1);
    tick();
    issue(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("fl_sel_a0", 32'(bus.fwd_a_sel), 0);
    check("fl_sel_b0", 32'(bus.fwd_b_sel), 0);
    tick();
    @(negedge clk);
    check("fl_sel_a1", 32'(bus.fwd_a_sel), 0);
    check("fl_sel_b1", 32'(bus.fwd_b_sel), 0);
    tick();
    nops(3);

    // add $0 ; lw $0 ; add $5,$0,$0
    issue(1, 2, 0, 1, 0, 0); tick();
    issue(9, 0, 0, 1, 1, 0); tick();
    issue(0, 0, 5, 1, 0, 0);
    @(negedge clk);
    check("r0_stall", 32'(bus.stall), 0);
    check("r0_bubble", 32'(bus.idex_bubble), 0);
    tick();
    issue(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("r0_sel_a", 32'(bus.fwd_a_sel), 0);
    check("r0_sel_b", 32'(bus.fwd_b_sel), 0);
    tick();
    nops(3);

    // reset with add $3 in MEM
    issue(1, 2, 3, 1, 0, 0); tick();
    issue(3, 3, 7, 1, 0, 0); tick();
    issue(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("prerst_sel_a", 32'(bus.fwd_a_sel), 2);
    check("prerst_sel_b", 32'(bus.fwd_b_sel), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    issue(3, 3, 7, 1, 0, 0);
    @(negedge clk);
    check("midrst_sel_a", 32'(bus.fwd_a_sel), 0);
    check("midrst_sel_b", 32'(bus.fwd_b_sel), 0);
    check("midrst_stall_cnt", bus.stall_count, 0);
    check("midrst_fwd_cnt", bus.fwd_count, 0);
    tick();
    issue(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("postrst_sel_a", 32'(bus.fwd_a_sel), 0);
    check("postrst_sel_b", 32'(bus.fwd_b_sel), 0);
    tick();
    nops(3);

    // three independent load-use stalls
    repeat (3) load_use();
    @(negedge clk);
`ifdef FWD_STATS_EN
    check("stats_stall_cnt", bus.stall_count, 3);
    check("stats_fwd_cnt", bus.fwd_count, 6);
`else
    check("nostats_stall_cnt", bus.stall_count, 0);
    check("nostats_fwd_cnt", bus.fwd_count, 0);
`endif
    tick();
    bus.stats_clr = 1'b1;
    tick();
    bus.stats_clr = 1'b0;
    @(negedge clk);
    check("clr_stall_cnt", bus.stall_count, 0);
    check("clr_fwd_cnt", bus.fwd_count, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
